// File: rtl/down_counter_timer.sv
// down_counter_timer
// Loadable down-counting timer with a one-cycle terminal-count pulse and an
// optional auto-reload mode for periodic strobes. A loaded value is held in
// reload_reg so the timer can be restarted from DONE, or reloaded at each
// terminal event, without a fresh load.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | loaded or reset, waiting for start; count holds
// RUN     | decrementing once per cycle unless pause is high
// PAUSED  | count frozen; returns to RUN when pause drops
// DONE    | terminal event reached without reload; count holds 0
module down_counter_timer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         start,
    input  logic         pause,
    input  logic         auto_reload,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [N-1:0] CNT_ZERO = '0;
    localparam logic [N-1:0] CNT_ONE  = N'(1);

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] count_nxt;
    logic [N-1:0] reload_reg;
    logic [N-1:0] reload_nxt;
    logic         tc_nxt;

    logic         count_is_zero;
    logic         count_is_one;
    logic         reload_is_zero;

    // Terminal comparisons shared by the next-state logic.
    always_comb begin
        count_is_zero  = (count == CNT_ZERO);
        count_is_one   = (count == CNT_ONE);
        reload_is_zero = (reload_reg == CNT_ZERO);
    end

    // State, count, reload value and tc pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            count      <= CNT_ZERO;
            reload_reg <= CNT_ZERO;
            tc         <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            tc         <= tc_nxt;
        end
    end

    // Next-state and datapath decisions; load overrides everything else.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;

        if (load) begin
            count_nxt  = load_data;
            reload_nxt = load_data;
            state_nxt  = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (count_is_zero) begin
                            state_nxt = ST_DONE;
                            tc_nxt    = 1'b1;
                        end else begin
                            state_nxt = ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (pause) begin
                        state_nxt = ST_PAUSED;
                    end else if (count_is_one) begin
                        tc_nxt = 1'b1;
                        if (auto_reload) begin
                            count_nxt = reload_reg;
                        end else begin
                            count_nxt = CNT_ZERO;
                            state_nxt = ST_DONE;
                        end
                    end else if (!count_is_zero) begin
                        count_nxt = count - CNT_ONE;
                    end else begin
                        // A zero count cannot be entered in RUN; recover to DONE.
                        state_nxt = ST_DONE;
                    end
                end

                ST_PAUSED: begin
                    if (!pause) begin
                        state_nxt = ST_RUN;
                    end
                end

                ST_DONE: begin
                    if (start) begin
                        if (reload_is_zero) begin
                            tc_nxt = 1'b1;
                        end else begin
                            count_nxt = reload_reg;
                            state_nxt = ST_RUN;
                        end
                    end
                end

                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // busy is a pure decode of the registered state.
    always_comb begin
        busy = (state == ST_RUN) || (state == ST_PAUSED);
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer
// Directed stimulus against a behavioural model of the timer, compared every
// falling edge, plus literal expectations taken from worked examples.
module tb_down_counter_timer;

    localparam int N = 4;

    logic         clk;
    logic         reset_n;
    logic         load;
    logic [N-1:0] load_data;
    logic         start;
    logic         pause;
    logic         auto_reload;
    logic [N-1:0] count;
    logic         tc;
    logic         busy;

    int checks;
    int failures;

    down_counter_timer #(.N(N)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .load_data   (load_data),
        .start       (start),
        .pause       (pause),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: "running" and "frozen" flags plus a finished flag instead of a state code.
    int  m_count;
    int  m_reload;
    bit  m_running;
    bit  m_frozen;
    bit  m_finished;
    bit  m_tc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_count    <= 0;
            m_reload   <= 0;
            m_running  <= 0;
            m_frozen   <= 0;
            m_finished <= 0;
            m_tc       <= 0;
        end else begin
            m_tc <= 0;
            if (load) begin
                m_count    <= int'(load_data);
                m_reload   <= int'(load_data);
                m_running  <= 0;
                m_frozen   <= 0;
                m_finished <= 0;
            end else if (m_frozen) begin
                if (!pause) begin
                    m_frozen  <= 0;
                    m_running <= 1;
                end
            end else if (m_running) begin
                if (pause) begin
                    m_frozen  <= 1;
                    m_running <= 0;
                end else if (m_count == 1) begin
                    m_tc <= 1;
                    if (auto_reload) begin
                        m_count <= m_reload;
                    end else begin
                        m_count    <= 0;
                        m_running  <= 0;
                        m_finished <= 1;
                    end
                end else begin
                    m_count <= m_count - 1;
                end
            end else if (m_finished) begin
                if (start) begin
                    if (m_reload == 0) begin
                        m_tc <= 1;
                    end else begin
                        m_count    <= m_reload;
                        m_finished <= 0;
                        m_running  <= 1;
                    end
                end
            end else begin
                if (start) begin
                    if (m_count == 0) begin
                        m_finished <= 1;
                        m_tc       <= 1;
                    end else begin
                        m_running <= 1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        checks = checks + 1;
        if (int'(count) != m_count || tc != m_tc || busy != (m_running || m_frozen)) begin
            failures = failures + 1;
            $display("FAIL model_cmp t=%0t count=%0d tc=%0b busy=%0b required count=%0d tc=%0b busy=%0b",
                     $time, count, tc, busy, m_count, m_tc, (m_running || m_frozen));
        end
    end

    task automatic expect_out(input string name, input int exp_count, input bit exp_tc, input bit exp_busy);
        checks = checks + 1;
        if (int'(count) != exp_count || tc != exp_tc || busy != exp_busy) begin
            failures = failures + 1;
            $display("FAIL %s count=%0d tc=%0b busy=%0b required count=%0d tc=%0b busy=%0b",
                     name, count, tc, busy, exp_count, exp_tc, exp_busy);
        end
    endtask

    task automatic drive(input bit l, input int d, input bit s, input bit p, input bit a);
        load        = l;
        load_data   = N'(d);
        start       = s;
        pause       = p;
        auto_reload = a;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        expect_out("reset_state", 0, 0, 0);
        reset_n = 1'b1;
        step();
        expect_out("idle_after_reset", 0, 0, 0);

        // One-shot from 4.
        drive(1, 4, 0, 0, 0); step(); expect_out("os_load", 4, 0, 0);
        drive(0, 0, 1, 0, 0); step(); expect_out("os_start", 4, 0, 1);
        drive(0, 0, 0, 0, 0); step(); expect_out("os_3", 3, 0, 1);
        step(); expect_out("os_2", 2, 0, 1);
        step(); expect_out("os_1", 1, 0, 1);
        step(); expect_out("os_tc", 0, 1, 0);
        step(); expect_out("os_done", 0, 0, 0);
        drive(0, 0, 0, 1, 0); step(); expect_out("os_done_pause", 0, 0, 0);

        // Auto-reload with period 3.
        drive(1, 3, 0, 0, 1); step(); expect_out("ar_load", 3, 0, 0);
        drive(0, 0, 1, 0, 1); step(); expect_out("ar_start", 3, 0, 1);
        drive(0, 0, 0, 0, 1); step(); expect_out("ar_2", 2, 0, 1);
        step(); expect_out("ar_1", 1, 0, 1);
        step(); expect_out("ar_reload1", 3, 1, 1);
        step(); step(); expect_out("ar_1b", 1, 0, 1);
        step(); expect_out("ar_reload2", 3, 1, 1);
        // Clearing auto_reload mid-run ends at the next terminal event.
        drive(0, 0, 1, 0, 0); step(); expect_out("ar_start_ignored", 2, 0, 1);
        drive(0, 0, 0, 0, 0); step(); step(); expect_out("ar_last", 0, 1, 0);

        // reload_reg == 1 produces tc every cycle.
        drive(1, 1, 0, 0, 1); step();
        drive(0, 0, 1, 0, 1); step(); expect_out("r1_start", 1, 0, 1);
        drive(0, 0, 0, 0, 1); step(); expect_out("r1_tc_a", 1, 1, 1);
        step(); expect_out("r1_tc_b", 1, 1, 1);
        step(); expect_out("r1_tc_c", 1, 1, 1);

        // Pause at count 4 for three cycles.
        drive(1, 6, 0, 0, 0); step(); expect_out("pz_load", 6, 0, 0);
        drive(0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0); step(); step(); expect_out("pz_4", 4, 0, 1);
        drive(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(); expect_out("pz_hold", 4, 0, 1);
        end
        drive(0, 0, 0, 0, 0); step(); expect_out("pz_resume", 4, 0, 1);
        step(); expect_out("pz_3", 3, 0, 1);
        step(); step(); expect_out("pz_1", 1, 0, 1);
        step(); expect_out("pz_tc", 0, 1, 0);
        step(); expect_out("pz_after", 0, 0, 0);

        // Load and start together while running at count 2.
        drive(1, 4, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0); step(); step(); expect_out("sim_at2", 2, 0, 1);
        drive(1, 5, 1, 1, 0); step(); expect_out("sim_load", 5, 0, 0);
        drive(0, 0, 0, 0, 0); step(); expect_out("sim_idle", 5, 0, 0);
        drive(0, 0, 1, 0, 0); step(); expect_out("sim_start", 5, 0, 1);
        drive(0, 0, 0, 0, 0); step(); expect_out("sim_4", 4, 0, 1);

        // Zero load, then DONE restarts.
        drive(1, 0, 0, 0, 0); step(); expect_out("z_load", 0, 0, 0);
        drive(0, 0, 1, 0, 0); step(); expect_out("z_tc", 0, 1, 0);
        drive(0, 0, 0, 0, 0); step(); expect_out("z_quiet", 0, 0, 0);
        drive(0, 0, 1, 0, 0); step(); expect_out("z_done_tc", 0, 1, 0);
        drive(1, 2, 0, 0, 0); step(); expect_out("z_load2", 2, 0, 0);
        drive(0, 0, 1, 0, 0); step(); expect_out("z_run2", 2, 0, 1);
        drive(0, 0, 0, 0, 0); step(); expect_out("z_1", 1, 0, 1);
        step(); expect_out("z_tc2", 0, 1, 0);
        drive(0, 0, 1, 0, 0); step(); expect_out("z_restart", 2, 0, 1);
        drive(0, 0, 0, 0, 0); step(); expect_out("z_r1", 1, 0, 1);
        step(); expect_out("z_tc3", 0, 1, 0);

        // Async reset mid-countdown from 15.
        drive(1, 15, 0, 0, 0); step(); expect_out("rst_load", 15, 0, 0);
        drive(0, 0, 1, 0, 0); step(); expect_out("rst_start", 15, 0, 1);
        drive(0, 0, 0, 0, 0);
        repeat (8) step();
        expect_out("rst_at7", 7, 0, 1);
        #2 reset_n = 1'b0;
        #1 expect_out("rst_async", 0, 0, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) step();
        expect_out("rst_after", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
